// File: rtl/ic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ic_pkg : shared types and helpers for the interconnect arbiter     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ic_pkg;

  localparam int IC_ADDR_W = 32;
  localparam int IC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    TOUT = 2'd3
  } state_t;

  typedef struct packed {
    logic                 write;
    logic [IC_ADDR_W-1:0] addr;
    logic [IC_DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [IC_DATA_W-1:0] rdata;
    logic                 err;
  } rsp_t;

  // Next round-robin position after ptr, wrapping at num_mst (up to 8 masters).
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int num_mst);
    return (int'(ptr) >= num_mst - 1) ? 3'd0 : ptr + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ic_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ic_rr_pick : combinational round-robin picker (first req from ptr) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ic_rr_pick
  import ic_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int PTR_W   = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               any_req
);

  logic [NUM_MST-1:0] rot;
  logic [PTR_W-1:0]   off;
  logic [PTR_W:0]     sum;

  // Rotate so bit 0 is the master at ptr; the lowest set bit is the winner.
  assign rot     = NUM_MST'({req, req} >> ptr);
  assign any_req = |req;

  always_comb begin
    off = '0;
    for (int j = NUM_MST - 1; j >= 0; j--) begin
      if (rot[j]) off = PTR_W'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W + 1)'(NUM_MST)) sum = sum - (PTR_W + 1)'(NUM_MST);
    grant = sum[PTR_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/ic_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ic_rr_arbiter : round-robin share of one target port, one txn in   |
// | flight, with response timeout.                Rev 1.0              |
// +--------------------------------------------------------------------+
module ic_rr_arbiter
  import ic_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MST-1:0]          m_req_valid,
  output logic [NUM_MST-1:0]          m_req_ready,
  input  logic [NUM_MST-1:0]          m_req_write,
  input  logic [NUM_MST*ADDR_W-1:0]   m_req_addr,
  input  logic [NUM_MST*DATA_W-1:0]   m_req_wdata,
  output logic [NUM_MST-1:0]          m_rsp_valid,
  input  logic [NUM_MST-1:0]          m_rsp_ready,
  output logic [DATA_W-1:0]           m_rsp_rdata,
  output logic                        m_rsp_err,
  output logic                        s_req_valid,
  input  logic                        s_req_ready,
  output logic                        s_req_write,
  output logic [ADDR_W-1:0]           s_req_addr,
  output logic [DATA_W-1:0]           s_req_wdata,
  input  logic                        s_rsp_valid,
  output logic                        s_rsp_ready,
  input  logic [DATA_W-1:0]           s_rsp_rdata,
  input  logic                        s_rsp_err,
  output logic [$clog2(NUM_MST)-1:0]  owner,
  output logic                        stray_rsp
);

  localparam int              PTR_W     = $clog2(NUM_MST);
  localparam logic [15:0]     TOUT_LAST = 16'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, owner_nxt, pick, ptr_after;
  logic [15:0]        cnt, cnt_nxt;
  logic               any_req, own_req_valid, own_rsp_ready, rsp_hs;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  ic_rr_pick #(
    .NUM_MST (NUM_MST),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (m_req_valid),
    .ptr     (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  assign own_req_valid = m_req_valid[owner];
  assign own_rsp_ready = m_rsp_ready[owner];
  assign rsp_hs        = s_rsp_valid && own_rsp_ready;
  assign ptr_after     = PTR_W'(rr_next(3'(owner), NUM_MST));

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (owner == PTR_W'(i)) begin
        sel_write = m_req_write[i];
        sel_addr  = m_req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = pick;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // A master withdrawing its request abandons the grant without moving rr_ptr.
        if (!own_req_valid) begin
          state_nxt = IDLE;
        end else if (s_req_ready) begin
          state_nxt = RSP;
          cnt_nxt   = '0;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          rr_ptr_nxt = ptr_after;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == TOUT_LAST) state_nxt = TOUT;
        end
      end
      TOUT: begin
        if (own_rsp_ready) begin
          rr_ptr_nxt = ptr_after;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_req_ready = '0;
    m_rsp_valid = '0;
    m_rsp_rdata = '0;
    m_rsp_err   = 1'b0;
    s_req_valid = 1'b0;
    s_req_write = 1'b0;
    s_req_addr  = '0;
    s_req_wdata = '0;
    s_rsp_ready = 1'b0;
    stray_rsp   = 1'b0;
    unique case (state)
      IDLE: begin
        // State already reads IDLE while rst is held; keep the drain path quiet until release.
        s_rsp_ready = ~rst;
        stray_rsp   = s_rsp_valid & ~rst;
      end
      REQ: begin
        s_rsp_ready        = ~rst;
        stray_rsp          = s_rsp_valid & ~rst;
        s_req_valid        = own_req_valid;
        s_req_write        = sel_write;
        s_req_addr         = sel_addr;
        s_req_wdata        = sel_wdata;
        m_req_ready[owner] = s_req_ready;
      end
      RSP: begin
        m_rsp_valid[owner] = s_rsp_valid;
        s_rsp_ready        = own_rsp_ready;
        m_rsp_rdata        = s_rsp_rdata;
        m_rsp_err          = s_rsp_err;
      end
      TOUT: begin
        m_rsp_valid[owner] = 1'b1;
        m_rsp_err          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ic_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ic_rr_arbiter : directed + randomized bench with a transaction- |
// | level reference model.                        Rev 1.0              |
// +--------------------------------------------------------------------+
module tb_ic_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   m_req_valid = '0, m_req_write = '0, m_rsp_ready = '0;
  logic [N*AW-1:0] m_req_addr = '0;
  logic [N*DW-1:0] m_req_wdata = '0;
  logic [N-1:0]   m_req_ready, m_rsp_valid;
  logic [DW-1:0]  m_rsp_rdata;
  logic           m_rsp_err;
  logic           s_req_valid, s_req_write, s_rsp_ready, stray_rsp;
  logic           s_req_ready = 1'b0, s_rsp_valid = 1'b0, s_rsp_err = 1'b0;
  logic [AW-1:0]  s_req_addr;
  logic [DW-1:0]  s_req_wdata;
  logic [DW-1:0]  s_rsp_rdata = '0;
  logic [1:0]     owner;

  int checks = 0;
  int failures = 0;

  ic_rr_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_write(s_req_write),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err),
    .owner(owner), .stray_rsp(stray_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic bit bitat(input logic [N-1:0] v, input int i);
    return |(v & onehot(i));
  endfunction

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (bitat(v, (p + k) % N)) return (p + k) % N;
    end
    return 0;
  endfunction

  // Transaction-level view: is a master being served, has the target taken
  // the request, how long it has waited, and whether it gave up.
  int ptr = 0, own = 0, waited = 0;
  bit busy = 0, acc = 0, expd = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 0; own <= 0; busy <= 0; acc <= 0; expd <= 0; waited <= 0;
    end else if (!busy) begin
      if (m_req_valid != '0) begin
        own <= first_from(m_req_valid, ptr);
        busy <= 1; acc <= 0; expd <= 0;
      end
    end else if (!acc) begin
      if (!bitat(m_req_valid, own)) busy <= 0;
      else if (s_req_ready) begin acc <= 1; waited <= 0; end
    end else if (!expd) begin
      if (s_rsp_valid && bitat(m_rsp_ready, own)) begin
        busy <= 0; ptr <= (own + 1) % N;
      end else begin
        waited <= waited + 1;
        if (waited + 1 >= TO) expd <= 1;
      end
    end else if (bitat(m_rsp_ready, own)) begin
      busy <= 0; ptr <= (own + 1) % N;
    end
  end

  logic [N-1:0]  e_mreqr, e_mrspv;
  logic          e_sreqv, e_srspr, e_stray, e_err, e_write;
  logic [DW-1:0] e_rdata, e_wdata;
  logic [AW-1:0] e_addr;

  always_comb begin
    e_mreqr = '0; e_mrspv = '0; e_sreqv = 0; e_srspr = 0; e_stray = 0;
    e_err = 0; e_write = 0; e_rdata = '0; e_wdata = '0; e_addr = '0;
    if (!rst) begin
      if (busy && !acc) begin
        e_sreqv = bitat(m_req_valid, own);
        e_mreqr = s_req_ready ? onehot(own) : '0;
        e_write = bitat(m_req_write, own);
        e_addr  = AW'(m_req_addr >> (own * AW));
        e_wdata = DW'(m_req_wdata >> (own * DW));
      end
      if (busy && acc) begin
        if (expd) begin
          e_mrspv = onehot(own); e_err = 1; e_rdata = '0;
        end else begin
          e_mrspv = s_rsp_valid ? onehot(own) : '0;
          e_srspr = bitat(m_rsp_ready, own);
          e_rdata = s_rsp_rdata; e_err = s_rsp_err;
        end
      end else begin
        e_srspr = 1; e_stray = s_rsp_valid;
      end
    end
  end

  always @(negedge clk) begin
    chk("owner", 64'(owner), 64'(own));
    chk("m_req_ready", 64'(m_req_ready), 64'(e_mreqr));
    chk("m_rsp_valid", 64'(m_rsp_valid), 64'(e_mrspv));
    chk("s_req_valid", 64'(s_req_valid), 64'(e_sreqv));
    chk("s_rsp_ready", 64'(s_rsp_ready), 64'(e_srspr));
    chk("stray_rsp", 64'(stray_rsp), 64'(e_stray));
    if (rst || e_sreqv) begin
      chk("s_req_write", 64'(s_req_write), 64'(e_write));
      chk("s_req_addr", 64'(s_req_addr), 64'(e_addr));
      chk("s_req_wdata", 64'(s_req_wdata), 64'(e_wdata));
    end
    if (rst || e_mrspv != '0) begin
      chk("m_rsp_rdata", 64'(m_rsp_rdata), 64'(e_rdata));
      chk("m_rsp_err", 64'(m_rsp_err), 64'(e_err));
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req_valid = m_req_valid | onehot(i);
    m_req_write = wr ? (m_req_write | onehot(i)) : (m_req_write & ~onehot(i));
    m_req_addr[i*AW +: AW]  = a;
    m_req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_rsp(input logic [N-1:0] who, input logic [DW-1:0] d, input string nm);
    s_rsp_valid = 1; s_rsp_rdata = d; s_rsp_err = 0; m_rsp_ready = '1;
    look();
    chk(nm, 64'(m_rsp_valid), 64'(who));
    tick();
    s_rsp_valid = 0; m_rsp_ready = '0;
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int pending;
    logic [N-1:0] hs_req;

    repeat (3) @(posedge clk);
    look();
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_s_rsp_ready", 64'(s_rsp_ready), 64'd0);
    chk("rst_s_req_valid", 64'(s_req_valid), 64'd0);
    tick(); rst = 0;

    // Single master 2 write
    tick();
    set_req(2, 1, 32'h100, 32'hA5); s_req_ready = 1;
    look(); chk("A_idle_sreqv", 64'(s_req_valid), 64'd0);
    tick();
    look();
    chk("A_sreqv", 64'(s_req_valid), 64'd1);
    chk("A_addr", 64'(s_req_addr), 64'h100);
    chk("A_wdata", 64'(s_req_wdata), 64'hA5);
    chk("A_mreqr", 64'(m_req_ready), 64'b0100);
    tick();
    m_req_valid = '0;
    s_rsp_valid = 1; s_rsp_rdata = 32'h5A; s_rsp_err = 0; m_rsp_ready = '1;
    look();
    chk("A_mrspv", 64'(m_rsp_valid), 64'b0100);
    chk("A_err", 64'(m_rsp_err), 64'd0);
    chk("A_mreqr_once", 64'(m_req_ready), 64'd0);
    tick();
    s_rsp_valid = 0; m_rsp_ready = '0;
    set_req(0, 0, 32'h0, 32'h0); set_req(3, 0, 32'h300, 32'h0);
    tick();
    look(); chk("A_rrptr3", 64'(owner), 64'd3);
    tick(); m_req_valid = '0;
    do_rsp(4'b1000, 32'h33, "A_rsp3");

    // All four masters requesting continuously from rr_ptr=0
    m_req_valid = '1; s_req_ready = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      look(); chk("B_grant", 64'(owner), 64'(k % N));
      tick();
      do_rsp(onehot(k % N), 32'(k), "B_rsp");
    end
    m_req_valid = '0;

    // Timeout on master 1, then a late stray response
    set_req(1, 0, 32'h40, 32'h0); s_rsp_rdata = 32'hDEAD;
    tick(); tick(); m_req_valid = '0;
    n = 0;
    while (n < 20) begin
      look();
      if (m_rsp_valid[1]) break;
      n++;
      tick();
    end
    chk("C_tout_cycles", 64'(n), 64'd8);
    chk("C_err", 64'(m_rsp_err), 64'd1);
    chk("C_rdata", 64'(m_rsp_rdata), 64'd0);
    m_rsp_ready = 4'b0010;
    tick(); m_rsp_ready = '0;
    repeat (4) tick();
    s_rsp_valid = 1;
    look();
    chk("C_stray", 64'(stray_rsp), 64'd1);
    chk("C_no_mrspv", 64'(m_rsp_valid), 64'd0);
    tick(); s_rsp_valid = 0;

    // Response in the same cycle the counter reaches TIMEOUT
    set_req(2, 0, 32'h80, 32'h0);
    tick(); tick(); m_req_valid = '0;
    for (int i = 0; i < TO - 1; i++) begin look(); tick(); end
    s_rsp_valid = 1; s_rsp_rdata = 32'h1234; s_rsp_err = 0; m_rsp_ready = 4'b0100;
    look();
    chk("D_mrspv", 64'(m_rsp_valid), 64'b0100);
    chk("D_rdata", 64'(m_rsp_rdata), 64'h1234);
    chk("D_err", 64'(m_rsp_err), 64'd0);
    tick(); s_rsp_valid = 0; m_rsp_ready = '0;
    look(); chk("D_no_tout", 64'(m_rsp_valid), 64'd0);

    // Reset while master 3 waits for its response
    set_req(3, 0, 32'hC0, 32'h0);
    tick(); tick(); m_req_valid = '0;
    look();
    #2 rst = 1;
    #1;
    chk("E_owner", 64'(owner), 64'd0);
    chk("E_mrspv", 64'(m_rsp_valid), 64'd0);
    chk("E_srspr", 64'(s_rsp_ready), 64'd0);
    tick(); rst = 0;
    set_req(1, 0, 32'h4, 32'h0); set_req(3, 0, 32'h8, 32'h0);
    s_req_ready = 0; s_rsp_valid = 1;
    look(); chk("E_stray", 64'(stray_rsp), 64'd1);
    tick(); s_rsp_valid = 0;
    look(); chk("E_rrptr0", 64'(owner), 64'd1);
    m_req_valid = '0;
    tick();

    // Master 0 withdraws while REQ is stalled
    set_req(0, 0, 32'h0, 32'h0); set_req(1, 0, 32'h10, 32'h0);
    tick();
    look();
    chk("F_owner0", 64'(owner), 64'd0);
    chk("F_stall_mreqr", 64'(m_req_ready), 64'd0);
    tick(); m_req_valid = 4'b0010;
    look(); chk("F_drop_sreqv", 64'(s_req_valid), 64'd0);
    tick(); tick();
    look(); chk("F_next_owner", 64'(owner), 64'd1);
    m_req_valid = '0;
    tick();

    // Randomized traffic
    pending = 0;
    for (int c = 0; c < 4000; c++) begin
      look();
      hs_req = m_req_valid & m_req_ready;
      if (s_req_valid && s_req_ready) pending++;
      if (s_rsp_valid && s_rsp_ready && pending > 0) pending--;
      tick();
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if (m_req_valid[i] && !hs_req[i]) begin
          if ($urandom_range(0, 49) == 0) m_req_valid[i] = 1'b0;
        end else begin
          m_req_valid[i] = ($urandom_range(0, 2) == 0);
          m_req_write[i] = 1'($urandom_range(0, 1));
          m_req_addr[i*AW +: AW]  = $urandom;
          m_req_wdata[i*DW +: DW] = $urandom;
        end
        m_rsp_ready[i] = ($urandom_range(0, 9) < 7);
      end
      s_req_ready = ($urandom_range(0, 9) < 6);
      s_rsp_valid = (pending > 0 && $urandom_range(0, 9) < 3) || ($urandom_range(0, 49) == 0);
      s_rsp_rdata = $urandom;
      s_rsp_err   = ($urandom_range(0, 7) == 0);
    end
    rst = 0;
    look();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
